pc_redirect_unit: RTL and testbench

- Front-end PC owner and consumer of the branch-resolution outputs (PCSel, PCBranch) from the execute stage.
- Holds the fetch PC and advances it by 4 each cycle.
- Applies taken-branch/jump redirects, squashing younger instructions through IF/ID and ID/EX flush pulses.
- Buffers a redirect when instruction memory is not ready to accept a new fetch address.

---
 rtl/pc_redirect_unit.sv | 86 ++++++++
 tb/tb_pc_redirect_unit.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: owns the fetch PC and applies execute-stage redirects.
// The PC advances by 4 each cycle. A taken branch or jump loads its target
// and squashes the younger instructions in IF/ID and ID/EX. If instruction
// memory cannot accept the target yet, the target is held in HOLD until it can.
module pc_redirect_unit #(
  parameter int unsigned         PC_WIDTH  = 9,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
  parameter int unsigned         CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 Stall,
  input  logic                 FetchReady,
  input  logic                 PCSel,
  input  logic [31:0]          PCBranch,
  output logic [PC_WIDTH-1:0]  PC,
  output logic                 FlushIF,
  output logic                 FlushID,
  output logic                 RedirectPending,
  output logic                 MisalignErr,
  output logic [CNT_WIDTH-1:0] RedirectCount
);

  typedef enum logic {RUN, HOLD} state_t;

  state_t              state;
  logic [PC_WIDTH-1:0] pending;
  logic [PC_WIDTH-1:0] tgt;
  logic                misaligned;
  logic                unused_hi;

  // Word-align the target and drop address bits beyond the PC width.
  assign tgt        = {PCBranch[PC_WIDTH-1:2], 2'b00};
  assign misaligned = |PCBranch[1:0];
  assign unused_hi  = ^PCBranch[31:PC_WIDTH];

  // PC, redirect FSM and all registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= RUN;
      PC              <= RESET_PC;
      pending         <= '0;
      FlushIF         <= 1'b0;
      FlushID         <= 1'b0;
      RedirectPending <= 1'b0;
      MisalignErr     <= 1'b0;
      RedirectCount   <= '0;
    end else begin
      // Squash while a redirect is captured, during HOLD and on the exit edge.
      FlushIF     <= PCSel || (state == HOLD);
      FlushID     <= PCSel || (state == HOLD);
      MisalignErr <= PCSel && misaligned;

      if (PCSel && (RedirectCount != '1))
        RedirectCount <= RedirectCount + CNT_WIDTH'(1);

      unique case (state)
        RUN: begin
          if (PCSel) begin
            if (FetchReady) begin
              PC <= tgt;
            end else begin
              pending         <= tgt;
              state           <= HOLD;
              RedirectPending <= 1'b1;
            end
          end else if (!Stall && FetchReady) begin
            PC <= PC + PC_WIDTH'(4);
          end
        end
        HOLD: begin
          if (FetchReady) begin
            // A redirect arriving on the release edge is newer than the buffered one.
            PC              <= PCSel ? tgt : pending;
            state           <= RUN;
            RedirectPending <= 1'b0;
          end else if (PCSel) begin
            pending <= tgt;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Self-checking bench for pc_redirect_unit: directed plan, randomized traffic
// and counter saturation, all checked against a behavioural model.
module tb_pc_redirect_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        Stall = 1'b0;
  logic        FetchReady = 1'b0;
  logic        PCSel = 1'b0;
  logic [31:0] PCBranch = '0;
  logic [8:0]  PC;
  logic        FlushIF, FlushID, RedirectPending, MisalignErr;
  logic [15:0] RedirectCount;

  int errors = 0;
  int checks = 0;

  pc_redirect_unit #(.PC_WIDTH(9), .RESET_PC(9'd0), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .Stall(Stall), .FetchReady(FetchReady),
    .PCSel(PCSel), .PCBranch(PCBranch), .PC(PC), .FlushIF(FlushIF),
    .FlushID(FlushID), .RedirectPending(RedirectPending),
    .MisalignErr(MisalignErr), .RedirectCount(RedirectCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural model: a redirect target is the branch address modulo 512
  // rounded down to a word; a waiting redirect is remembered as a flag plus address.
  int m_pc, m_pend, m_cnt;
  bit m_waiting, m_flush, m_misal;

  function automatic int fmt(input logic [31:0] b);
    return int'(b % 512) & ~3;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc <= 0; m_pend <= 0; m_cnt <= 0;
      m_waiting <= 0; m_flush <= 0; m_misal <= 0;
    end else begin
      m_flush <= PCSel || m_waiting;
      m_misal <= PCSel && (PCBranch % 4 != 0);
      m_cnt   <= (PCSel && m_cnt < 65535) ? m_cnt + 1 : m_cnt;
      if (FetchReady && (PCSel || m_waiting)) begin
        m_pc      <= PCSel ? fmt(PCBranch) : m_pend;
        m_waiting <= 0;
      end else if (PCSel) begin
        m_pend    <= fmt(PCBranch);
        m_waiting <= 1;
      end else if (!m_waiting && !Stall && FetchReady) begin
        m_pc <= (m_pc + 4) % 512;
      end
    end
  end

  bit cmp_en = 1'b0;

  // Compare every output against the model away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_PC", int'(PC), m_pc);
      chk("model_FlushIF", int'(FlushIF), int'(m_flush));
      chk("model_FlushID", int'(FlushID), int'(m_flush));
      chk("model_RedirectPending", int'(RedirectPending), int'(m_waiting));
      chk("model_MisalignErr", int'(MisalignErr), int'(m_misal));
      chk("model_RedirectCount", int'(RedirectCount), m_cnt);
    end
  end

  // Apply inputs for the next rising edge, then return just after it.
  task automatic cyc(input logic s, input logic fr, input logic sel, input logic [31:0] br);
    Stall = s; FetchReady = fr; PCSel = sel; PCBranch = br;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string name, input int pc, input int fl, input int rp, input int cnt);
    chk({name, "_PC"}, int'(PC), pc);
    chk({name, "_FlushIF"}, int'(FlushIF), fl);
    chk({name, "_FlushID"}, int'(FlushID), fl);
    chk({name, "_Pending"}, int'(RedirectPending), rp);
    chk({name, "_Count"}, int'(RedirectCount), cnt);
  endtask

  initial begin
    #3;
    chk_state("reset", 0, 0, 0, 0);
    chk("reset_Misalign", int'(MisalignErr), 0);
    #9 rst_n = 1'b1;
    cmp_en = 1'b1;

    // 1: free-running increment
    chk("t1_pc0", int'(PC), 0);
    for (int i = 1; i <= 5; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 32'h0);
      chk_state("t1_run", 4 * i, 0, 0, 0);
    end

    // 2: immediate redirect, single flush pulse
    cyc(1'b0, 1'b1, 1'b1, 32'h40);
    chk_state("t2_redir", 32'h40, 1, 0, 1);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    chk_state("t2_after", 32'h44, 0, 0, 1);

    // 3: redirect buffered while fetch is not ready
    cyc(1'b0, 1'b0, 1'b1, 32'h80);
    chk_state("t3_hold0", 32'h44, 1, 1, 2);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 32'h0);
      chk_state("t3_hold", 32'h44, 1, 1, 2);
    end
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    chk_state("t3_release", 32'h80, 1, 0, 2);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    chk_state("t3_done", 32'h84, 0, 0, 2);

    // 4: newest pending target wins
    cyc(1'b0, 1'b0, 1'b1, 32'h80);
    cyc(1'b1, 1'b0, 1'b1, 32'h20);
    chk_state("t4_replace", 32'h84, 1, 1, 4);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    chk_state("t4_release", 32'h20, 1, 0, 4);

    // 5: redirect beats Stall, misaligned target, wrap at top of PC space
    cyc(1'b1, 1'b1, 1'b1, 32'h1F6);
    chk_state("t5_redir", 32'h1F4, 1, 0, 5);
    chk("t5_misalign", int'(MisalignErr), 1);
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    chk("t5_stall_pc", int'(PC), 32'h1F4);
    chk("t5_misalign_off", int'(MisalignErr), 0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    chk("t5_pc_1f8", int'(PC), 32'h1F8);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    chk("t5_pc_1fc", int'(PC), 32'h1FC);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    chk("t5_wrap", int'(PC), 0);
    cyc(1'b0, 1'b1, 1'b1, 32'hFFFF_FE48);
    chk("t5_high_bits", int'(PC), 32'h48);

    // 6: asynchronous reset in the middle of HOLD
    cyc(1'b0, 1'b0, 1'b1, 32'h60);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    chk_state("t6_async", 0, 0, 0, 0);
    FetchReady = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("t6_pc0", int'(PC), 0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    chk_state("t6_pc4", 4, 0, 0, 0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    chk("t6_pc8", int'(PC), 8);

    // Randomized traffic checked by the model.
    for (int i = 0; i < 3000; i++) begin
      cyc(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) != 0),
          1'($urandom_range(0, 4) == 0), $urandom);
    end

    // Drive the counter into saturation with back-to-back redirects.
    for (int i = 0; i < 65540; i++) begin
      cyc(1'b0, 1'b1, 1'b1, $urandom);
    end
    chk("sat_count", int'(RedirectCount), 32'hFFFF);
    chk("sat_flush", int'(FlushIF), 1);

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
